// File: rtl/vend_ctrl_if.sv
`default_nettype none
// ============================================================================
// vend_ctrl_if : coin-validator inputs and actuator outputs of vend_ctrl
// Revision     : 1.0  (VEND_SALES_COUNT_EN adds sales_cnt)
// ============================================================================
interface vend_ctrl_if #(
  parameter int CREDIT_W = 4
) ();
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                cancel;
  logic                dispense;
  logic                change_out;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
`ifdef VEND_SALES_COUNT_EN
  logic [15:0]         sales_cnt;

  modport master (
    output coin_valid, coin_type, cancel,
    input  dispense, change_out, coin_reject, credit, busy, sales_cnt
  );
  modport slave (
    input  coin_valid, coin_type, cancel,
    output dispense, change_out, coin_reject, credit, busy, sales_cnt
  );
`else
  modport master (
    output coin_valid, coin_type, cancel,
    input  dispense, change_out, coin_reject, credit, busy
  );
  modport slave (
    input  coin_valid, coin_type, cancel,
    output dispense, change_out, coin_reject, credit, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// vend_ctrl : coin-operated vending controller (credit, dispense, change)
// Revision  : 1.0  (optional VEND_SALES_COUNT_EN: saturating sales counter)
// ============================================================================
module vend_ctrl #(
  parameter int PRICE           = 3,
  parameter int MAX_CREDIT      = 6,
  parameter int CREDIT_W        = 4,
  parameter int DISPENSE_CYCLES = 4
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  vend_ctrl_if.slave bus
);
  localparam int TIMER_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CREDIT_W:0]  PRICE_X    = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]  MAX_X      = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DISPENSE_CYCLES - 1);
  localparam logic [CREDIT_W-1:0] ONE       = CREDIT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                dispense_q, dispense_d;
  logic                change_q, change_d;
  logic                reject_q, reject_d;
  logic                busy_q, busy_d;
  logic [1:0]          coin_units;
  logic [CREDIT_W:0]   sum_x;

  always_comb begin
    case (bus.coin_type)
      2'b01:   coin_units = 2'd1;
      2'b10:   coin_units = 2'd2;
      default: coin_units = 2'd0;
    endcase
    // One extra bit so an over-limit coin is caught instead of wrapping.
    sum_x = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, coin_units};

    state_d    = state_q;
    credit_d   = credit_q;
    timer_d    = timer_q;
    dispense_d = 1'b0;
    change_d   = 1'b0;
    reject_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (bus.cancel) begin
          reject_d = bus.coin_valid;
          if (state_q == ST_COLLECT) begin
            state_d  = ST_CHANGE;
            change_d = 1'b1;
            credit_d = credit_q - ONE;
          end
        end else if (bus.coin_valid) begin
          if (coin_units != 2'd0 && sum_x <= MAX_X) begin
            if (sum_x >= PRICE_X) begin
              state_d    = ST_DISPENSE;
              credit_d   = CREDIT_W'(sum_x - PRICE_X);
              dispense_d = 1'b1;
              timer_d    = TIMER_LOAD;
            end else begin
              state_d  = ST_COLLECT;
              credit_d = CREDIT_W'(sum_x);
            end
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        reject_d = bus.coin_valid;
        if (timer_q == '0) begin
          if (credit_q != '0) begin
            state_d  = ST_CHANGE;
            change_d = 1'b1;
            credit_d = credit_q - ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d    = timer_q - TIMER_W'(1);
          dispense_d = 1'b1;
        end
      end
      ST_CHANGE: begin
        reject_d = bus.coin_valid;
        // Credit already reflects the pulse on the wire; 0 here means it was the last.
        if (change_q) begin
          if (credit_q == '0) state_d = ST_IDLE;
        end else begin
          change_d = 1'b1;
          credit_d = credit_q - ONE;
        end
      end
    endcase

    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      timer_q    <= '0;
      dispense_q <= 1'b0;
      change_q   <= 1'b0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      timer_q    <= timer_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
    end
  end

`ifdef VEND_SALES_COUNT_EN
  logic [15:0] sales_q, sales_d;

  always_comb begin
    sales_d = sales_q;
    if (state_d == ST_DISPENSE && state_q != ST_DISPENSE && sales_q != 16'hFFFF)
      sales_d = sales_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sales_q <= 16'd0;
    else        sales_q <= sales_d;
  end

  assign bus.sales_cnt = sales_q;
`endif

  assign bus.dispense    = dispense_q;
  assign bus.change_out  = change_q;
  assign bus.coin_reject = reject_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
endmodule
`default_nettype wire
